dmem_ctrl: RTL and testbench

- Parametrised successor data memory for the RISCV core: byte-addressed, word-organised SRAM array with byte/half/word loads and stores.
- Performs signed/unsigned load extension and misalignment/range checking.
- Uses a valid/ready request-response handshake with registered (synchronous) read data.
- Sits between the core's MEM stage (or LSU) and the on-chip data array; replaces the single-cycle, word-only combinational-read memory.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_fmt.sv | 49 ++++
 rtl/dmem_ctrl.sv | 134 +++++++++++++
 tb/tb_dmem_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size encodings, FSM states
// and the word-index width helper.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t READ = 2'd1;
  localparam state_t RESP = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) result = i + 1;
    return result;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane logic: store byte enables / data replication and
// load lane selection with sign or zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_rdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the data into every lane lets the byte enables alone pick the target bytes.
  always_comb begin
    st_be        = 4'b0000;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_B: begin
        st_be        = 4'b0001 << st_lane;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_be        = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SZ_W: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[8*ld_lane +: 8];
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SZ_B:    ld_rdata = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_rdata = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_rdata = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with valid/ready request/response and registered reads.
// Optional perf counters (ld_cnt/st_cnt/err_cnt) are enabled by DMEM_PERF_CNT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
`ifdef DMEM_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int IW = clog2(DEPTH);

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] rd_idx;
  logic [1:0]    ld_lane;
  logic [1:0]    ld_size;
  logic          ld_unsigned;
  logic          acc;
  logic          err;
  logic          in_range;
  logic [IW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   ld_rdata;

  assign req_ready = (state == IDLE) & ~rst;
  assign rsp_valid = (state == RESP);
  assign acc       = req_valid & req_ready;
  assign widx      = req_addr[IW+1:2];
  assign in_range  = {{(66-AW){1'b0}}, req_addr[AW-1:2]} < 64'(DEPTH);

  always_comb begin
    err = ~in_range;
    if (req_size == SZ_H && req_addr[0]) err = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00) err = 1'b1;
    if (req_size == 2'b11) err = 1'b1;
  end

  dmem_lane_fmt u_fmt (
    .st_size      (req_size),
    .st_lane      (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_be        (be),
    .st_wdata_rep (wdata_rep),
    .ld_size      (ld_size),
    .ld_lane      (ld_lane),
    .ld_unsigned  (ld_unsigned),
    .ld_word      (mem[rd_idx]),
    .ld_rdata     (ld_rdata)
  );

  // The array has no reset; stores commit on their acceptance edge.
  always_ff @(posedge clk) begin
    if (acc && req_we && !err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rd_idx      <= '0;
      ld_lane     <= '0;
      ld_size     <= '0;
      ld_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            rsp_rdata <= '0;
            rsp_err   <= err;
            if (err || req_we) begin
              state <= RESP;
            end else begin
              state       <= READ;
              rd_idx      <= widx;
              ld_lane     <= req_addr[1:0];
              ld_size     <= req_size;
              ld_unsigned <= req_unsigned;
            end
          end
        end
        READ: begin
          rsp_rdata <= ld_rdata;
          state     <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt  <= '0;
      st_cnt  <= '0;
      err_cnt <= '0;
    end else if (acc) begin
      if (err)         err_cnt <= err_cnt + CNT_W'(1);
      else if (req_we) st_cnt  <= st_cnt + CNT_W'(1);
      else             ld_cnt  <= ld_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: loads/stores, extension, faults,
// backpressure and asynchronous reset (counters checked when DMEM_PERF_CNT_EN is set).
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]   ld_cnt, st_cnt, err_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] obsData;
  logic        obsErr;
  int          obsLat;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .ld_cnt       (ld_cnt),
    .st_cnt       (st_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction with rsp_ready held high; latency counted from the accept edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    obsLat = 1;
    while (!rsp_valid && obsLat < 8) begin
      @(posedge clk); #1;
      obsLat++;
    end
    obsData = rsp_rdata;
    obsErr  = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] expData, input logic expErr, input int expLat);
    applyStimulus(we, size, uns, addr, wdata);
    checkOutput({tag, "_data"}, obsData, expData);
    checkOutput({tag, "_err"}, {31'b0, obsErr}, {31'b0, expErr});
    checkOutput({tag, "_lat"}, obsLat, expLat);
    checkOutput({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #12;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    checkOutput("rel_req_ready", {31'b0, req_ready}, 32'd1);

    txn("sw10", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    txn("lw10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    txn("lb13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    txn("lbu13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    txn("lh12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    txn("lhu10", 1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);

    txn("sb11", 1'b1, SZ_B, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0, 1'b0, 1);
    txn("lw_after_sb", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2);
    txn("sh12", 1'b1, SZ_H, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 1);
    txn("lw_after_sh", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

    txn("sw20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h01020304, 32'h0, 1'b0, 1);
    txn("sw00", 1'b1, SZ_W, 1'b0, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    txn("lw12_mis", 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
    txn("sh21_mis", 1'b1, SZ_H, 1'b0, 32'h21, 32'h0000BEEF, 32'h0, 1'b1, 1);
    txn("lw20_keep", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0, 2);
    txn("size11", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    txn("lw10_keep", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);
    txn("sw_oor", 1'b1, SZ_W, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    txn("lw_oor", 1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    txn("lw00_keep", 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    // Backpressure: response must hold steady while rsp_ready is low.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_H; req_unsigned = 1'b0;
    req_addr = 32'h12; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_valid_rise", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata, 32'h00001234);
      checkOutput("bp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bp_req_ready_back", {31'b0, req_ready}, 32'd1);

    // Reset while a store response is pending clears the response at once.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h30;
    req_wdata = 32'h0BADC0DE; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0; req_we = 1'b0;
    checkOutput("resp_pending", {31'b0, rsp_valid}, 32'd1);
    #2 rst = 1'b1; #1;
    checkOutput("rst_resp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_resp_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1; #1;
    checkOutput("rst_resp_rel", {31'b0, req_ready}, 32'd1);

    // Reset while in READ drops the load with no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h20;
    @(posedge clk); #1 req_valid = 1'b0;
    #2 rst = 1'b1; #1;
    checkOutput("rst_read_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_read_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_read_hold", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    checkOutput("rst_read_rel", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    checkOutput("rst_read_dropped", {31'b0, rsp_valid}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("cnt_ld_rst", ld_cnt, 32'd0);
    checkOutput("cnt_st_rst", st_cnt, 32'd0);
    checkOutput("cnt_err_rst", err_cnt, 32'd0);
`endif

    txn("lw30_kept", 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, 32'h0BADC0DE, 1'b0, 2);
    txn("lw10_kept", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);
    txn("lw00_kept", 1'b0, SZ_W, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 2);
`ifdef DMEM_PERF_CNT_EN
    txn("sb_cnt", 1'b1, SZ_B, 1'b0, 32'h40, 32'h7, 32'h0, 1'b0, 1);
    txn("err_cnt_req", 1'b0, SZ_H, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
    checkOutput("cnt_ld", ld_cnt, 32'd3);
    checkOutput("cnt_st", st_cnt, 32'd1);
    checkOutput("cnt_err", err_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
